// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: opcode decode, datapath control sequencing,
// memory wait handshake, illegal-opcode flag and retired-instruction counter.
module mc_main_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore control word for a state; unused codes decode to all strobes off.
  function automatic ctrl_t decode_ctrl(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE:   c.alu_src_b = 2'b11;
      S_MEM_ADDR, S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_ADDI_WB:  c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e           state_q, state_d;
  ctrl_t            ctrl_q;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;
  logic             known_op;
  logic             retire;
  logic             fetch_go;

  assign known_op = (opcode == OP_R)   || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ) || (opcode == OP_J)  || (opcode == OP_ADDI);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:         state_d = S_EXECUTE;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_R_WB;
      S_ADDI_EX:   state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEM_WRITE: retire = mem_ready;
      default:     retire = 1'b0;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= decode_ctrl(S_FETCH);
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= decode_ctrl(state_d);
      illegal_q <= (state_q == S_DECODE) && !known_op;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  // IR and PC load in FETCH follow mem_ready in the same cycle.
  assign fetch_go      = (state_q == S_FETCH) && mem_ready;
  assign ir_write      = fetch_go;
  assign pc_write      = ctrl_q.pc_write | fetch_go;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign i_or_d        = ctrl_q.i_or_d;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_dst       = ctrl_q.reg_dst;
  assign reg_write     = ctrl_q.reg_write;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign pc_source     = ctrl_q.pc_source;
  assign alu_op        = ctrl_q.alu_op;
  assign state         = state_q;
  assign illegal_op    = illegal_q;
  assign instr_count   = count_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: directed scenarios plus random instruction streams,
// checked against an instruction-level model that tracks each instruction's state path.
module tb_mc_main_control;

  localparam int CNT_W = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic             mem_to_reg, ir_write, reg_dst, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, pc_source, alu_op;
  logic [3:0]       state;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  mc_main_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .state(state), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: queue of states the current instruction still has to visit.
  int               path[$];
  logic [CNT_W-1:0] m_cnt;
  logic             m_ill;

  function automatic void route(input logic [5:0] op);
    case (op)
      OP_R:    path = {1, 6, 7};
      OP_LW:   path = {1, 2, 3, 4};
      OP_SW:   path = {1, 2, 5};
      OP_BEQ:  path = {1, 8};
      OP_J:    path = {1, 9};
      OP_ADDI: path = {1, 10, 11};
      default: path = {1};
    endcase
  endfunction

  // Expected control vector in the order
  // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,mem_to_reg,ir_write,reg_dst,reg_write,alu_src_a,alu_src_b,pc_source,alu_op}
  function automatic logic [16:0] exp_ctrl(input int s, input logic mr);
    logic pw, pwc, iod, mrd, mwr, m2r, irw, rd, rw, asa;
    logic [1:0] asb, pcs, aop;
    {pw, pwc, iod, mrd, mwr, m2r, irw, rd, rw, asa} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      1:  asb = 2'b11;
      2, 10: begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iod = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      11: rw = 1;
      8:  begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
      9:  begin pw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, m2r, irw, rd, rw, asa, asb, pcs, aop};
  endfunction

  function automatic int exp_state();
    return (path.size() != 0) ? path[0] : 0;
  endfunction

  task automatic step(input logic r, input logic mr, input logic [5:0] op);
    int s;
    logic nill;
    @(negedge clk);
    reset = r; mem_ready = mr; opcode = op;
    #1;
    s = exp_state();
    check("state", 32'(state), 32'(s));
    check("ctrl", 32'({pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
                       ir_write, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op}),
          32'(exp_ctrl(s, mr)));
    check("illegal_op", 32'(illegal_op), 32'(m_ill));
    check("instr_count", 32'(instr_count), 32'(m_cnt));
    @(posedge clk);
    if (r) begin
      path.delete();
      m_cnt = '0;
      m_ill = 1'b0;
    end else begin
      nill = 1'b0;
      if (path.size() == 0) begin
        if (mr) route(op);
      end else if (!((path[0] == 3 || path[0] == 5) && !mr)) begin
        s = path.pop_front();
        if (path.size() == 0) begin
          if (s == 1) nill = 1'b1;
          else        m_cnt = m_cnt + 1'b1;
        end
      end
      m_ill = nill;
    end
  endtask

  task automatic run_instr(input logic [5:0] op);
    step(1'b0, 1'b1, op);
    while (path.size() != 0) step(1'b0, 1'b1, op);
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] legal[6];
    legal = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    reset = 1'b1; mem_ready = 1'b0; opcode = OP_R;
    repeat (2) @(posedge clk);
    path.delete(); m_cnt = '0; m_ill = 1'b0;

    // Reset held, then FETCH holds while memory is not ready.
    step(1'b1, 1'b0, OP_R);
    repeat (3) step(1'b0, 1'b0, OP_R);

    run_instr(OP_R);

    // lw with three wait cycles in MEM_READ.
    repeat (3) step(1'b0, 1'b1, OP_LW);
    repeat (3) step(1'b0, 1'b0, OP_LW);
    while (path.size() != 0) step(1'b0, 1'b1, OP_LW);

    step(1'b1, 1'b0, OP_R);
    run_instr(OP_BEQ);
    run_instr(OP_J);

    run_instr(6'b111111);
    step(1'b0, 1'b0, OP_R);

    // Reset while in MEM_WRITE abandons the store.
    repeat (3) step(1'b0, 1'b1, OP_SW);
    step(1'b0, 1'b0, OP_SW);
    step(1'b1, 1'b0, OP_SW);
    step(1'b0, 1'b0, OP_SW);

    // 16 addi retirements wrap the 4-bit counter back to 0.
    step(1'b1, 1'b0, OP_R);
    repeat (16) run_instr(OP_ADDI);
    step(1'b0, 1'b0, OP_R);

    // Random instruction stream; opcode only changes while in FETCH.
    op = OP_R;
    for (int i = 0; i < 3000; i++) begin
      if (path.size() == 0) begin
        int k;
        k = int'($urandom_range(0, 7));
        op = (k < 6) ? legal[k] : 6'($urandom);
      end
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), op);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multi-cycle MIPS main control FSM.
- Decodes the 6-bit opcode and sequences datapath control across cycles.
- Generates the 2-bit alu_op consumed by the existing ALU control block, which combines alu_op with funct[5:0] to form the 4-bit ALU select.
- Also provides a memory wait handshake, an illegal-opcode flag and a retired-instruction counter.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
opcode  input  6  instruction[31:26] from IR; sampled only in DECODE
mem_ready  input  1  memory access completes this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero
i_or_d  output  1  0=PC addresses memory, 1=ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_to_reg  output  1  1=MDR to register file
ir_write  output  1  IR load
reg_dst  output  1  1=rd, 0=rt
reg_write  output  1  register file write
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
pc_source  output  2  00=ALU, 01=ALUOut, 10=jump target
alu_op  output  2  00=add, 01=sub, 10=use funct
state  output  4  current state encoding, for debug
illegal_op  output  1  one-cycle pulse on unknown opcode
instr_count  output  CNT_W  retired instructions, wraps

Behaviour:
- Synchronous, active-high reset:
  - state<=FETCH (0); instr_count<=0; illegal_op<=0.
  - Outputs then show FETCH decode on the first cycle after reset.
  - Reset mid-instruction abandons it; no count increment.
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11. Codes 12-15 -> FETCH next cycle, all strobes 0.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Transitions:
  - FETCH: -> DECODE only when mem_ready=1; else hold.
  - DECODE routes on opcode: R->EXECUTE, lw/sw->MEM_ADDR, beq->BRANCH, j->JUMP, addi->ADDI_EX, other->FETCH.
  - MEM_ADDR -> MEM_READ (lw) or MEM_WRITE (sw); opcode is held stable by the IR.
  - MEM_READ: hold until mem_ready, then -> MEM_WB.
  - MEM_WRITE: hold until mem_ready, then -> FETCH.
  - EXECUTE->R_WB; ADDI_EX->ADDI_WB.
  - MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP -> FETCH.
- Outputs: all 0 unless listed.
  - FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ready (Mealy gating; the only Mealy outputs).
  - DECODE: alu_src_b=11, alu_op=00.
  - MEM_ADDR, ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEM_READ: mem_read=1, i_or_d=1.
  - MEM_WRITE: mem_write=1, i_or_d=1.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10.
  - R_WB: reg_write=1, reg_dst=1.
  - ADDI_WB: reg_write=1.
  - BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
- illegal_op: registered; high exactly one cycle (the FETCH cycle after DECODE) for an unknown opcode. instr_count does not increment.
- instr_count: +1 on each exit from MEM_WB, MEM_WRITE (with mem_ready), R_WB, ADDI_WB, BRANCH, JUMP. Wraps all-ones -> 0.
- Cycle counts with mem_ready held 1: R 4, lw 5, sw 4, beq 3, j 3, addi 4.

Test Plan:
- Reset: reset=1 two cycles, mem_ready=0 -> state=0, mem_read=1, pc_write=0, ir_write=0, instr_count=0; holds FETCH while mem_ready=0.
- R-type: opcode=000000, mem_ready=1 -> states 0,1,6,7,0; alu_op=10 in EXECUTE; reg_write=1, reg_dst=1 in R_WB; instr_count=1.
- lw with wait: opcode=100011, mem_ready low 3 cycles in MEM_READ -> state=3 held 4 cycles with mem_read=1, i_or_d=1, then MEM_WB mem_to_reg=1, reg_write=1.
- beq then j: opcode=000100 -> alu_op=01, pc_write_cond=1, pc_source=01; then opcode=000010 -> pc_write=1, pc_source=10; instr_count=2.
- Illegal: opcode=111111 -> DECODE->FETCH, illegal_op=1 one cycle, instr_count unchanged.
- Reset mid-sw: assert reset in MEM_WRITE -> next state=0, mem_write=0, count unchanged. Separately, preload via 2^CNT_W-1 retirements (CNT_W=4, 15 addi) and retire one more -> instr_count wraps to 0.
